// File: rtl/ddr_mac_xfer_sched.sv
// DDR-to-MAC read transfer scheduler: descriptor queue, chunk splitter and a
// one-outstanding-transfer FSM. Optional WAIT watchdog enabled by SCHED_TIMEOUT_EN.
module ddr_mac_xfer_sched #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter logic [31:0] MAX_CHUNK      = 32'h0000_0400,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        ddr_user_clk,
    input  logic        ddr_user_rst,
    input  logic [63:0] desc_data,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic        abort,
    output logic        ddr_to_mac_start,
    output logic [63:0] ddr_to_mac_desc,
    input  logic        ddr_to_mac_done,
    output logic        xfer_done,
    output logic [15:0] desc_cnt,
    output logic        busy,
    output logic        err_timeout,
    input  logic        err_clr
);

    localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, NEXT} state_t;

    state_t        state;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic          sync1, sync2, sync2_d, done_evt;
    logic [63:0]   ld_desc;
    logic [31:0]   cur_addr, rem, chunk;
    logic [31:0]   rem_nxt, addr_nxt;

    function automatic logic [31:0] clip(input logic [31:0] r);
        return (r > MAX_CHUNK) ? MAX_CHUNK : r;
    endfunction

    assign desc_ready = (count != DEPTH_C);
    assign push       = desc_valid && desc_ready && !abort;
    assign pop        = (state == IDLE) && (count != '0) && !abort;
    assign busy       = (state != IDLE) || (count != '0);
    assign rem_nxt    = rem - chunk;
    assign addr_nxt   = cur_addr + chunk;

    always_ff @(posedge ddr_user_clk) begin
        if (push) mem[wr_ptr] <= desc_data;
    end

    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Done arrives from another clock: two-flop synchronizer, then a registered
    // rising-edge detect so a held level yields a single event.
    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync2_d  <= 1'b0;
            done_evt <= 1'b0;
        end else begin
            sync1    <= ddr_to_mac_done;
            sync2    <= sync1;
            sync2_d  <= sync2;
            done_evt <= sync2 && !sync2_d;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    logic [31:0] wait_cnt;
`else
    logic unused_ok;
    assign unused_ok   = ^{err_clr, TO_LIMIT};
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge ddr_user_clk) begin
        if (ddr_user_rst) begin
            state            <= IDLE;
            ld_desc          <= '0;
            cur_addr         <= '0;
            rem              <= '0;
            chunk            <= '0;
            ddr_to_mac_start <= 1'b0;
            ddr_to_mac_desc  <= '0;
            xfer_done        <= 1'b0;
            desc_cnt         <= '0;
`ifdef SCHED_TIMEOUT_EN
            wait_cnt         <= '0;
            err_timeout      <= 1'b0;
`endif
        end else begin
            ddr_to_mac_start <= 1'b0;
            xfer_done        <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            // Cleared here so a timeout later in this block overrides it.
            if (err_clr) err_timeout <= 1'b0;
`endif
            if (abort) begin
                state <= IDLE;
                rem   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (count != '0) begin
                            ld_desc <= mem[rd_ptr];
                            state   <= LOAD;
                        end
                    end
                    LOAD: begin
                        cur_addr <= ld_desc[31:0];
                        rem      <= ld_desc[63:32];
                        if (ld_desc[63:32] == '0) begin
                            state <= IDLE;
                        end else begin
                            // Start is raised on entry so it is high for the whole ISSUE cycle.
                            chunk            <= clip(ld_desc[63:32]);
                            ddr_to_mac_start <= 1'b1;
                            ddr_to_mac_desc  <= {clip(ld_desc[63:32]), ld_desc[31:0]};
                            state            <= ISSUE;
                        end
                    end
                    ISSUE: begin
`ifdef SCHED_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (done_evt) begin
                            state <= NEXT;
                        end
`ifdef SCHED_TIMEOUT_EN
                        else if (wait_cnt == TO_LIMIT - 1'b1) begin
                            err_timeout <= 1'b1;
                            rem         <= '0;
                            state       <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
`endif
                    end
                    NEXT: begin
                        cur_addr <= addr_nxt;
                        rem      <= rem_nxt;
                        if (rem_nxt == '0) begin
                            xfer_done <= 1'b1;
                            desc_cnt  <= desc_cnt + 1'b1;
                            state     <= IDLE;
                        end else begin
                            chunk            <= clip(rem_nxt);
                            ddr_to_mac_start <= 1'b1;
                            ddr_to_mac_desc  <= {clip(rem_nxt), addr_nxt};
                            state            <= ISSUE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr_mac_xfer_sched.sv
// Directed bench for ddr_mac_xfer_sched; timeout steps run when SCHED_TIMEOUT_EN is defined.
module tb_ddr_mac_xfer_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] desc_data;
    logic        desc_valid;
    logic        desc_ready;
    logic        abort;
    logic        start;
    logic [63:0] xdesc;
    logic        done;
    logic        xfer_done;
    logic [15:0] desc_cnt;
    logic        busy;
    logic        err_timeout;
    logic        err_clr;

    int n_cmp = 0;
    int n_err = 0;

    ddr_mac_xfer_sched #(
        .FIFO_DEPTH(8),
        .MAX_CHUNK(32'h0000_0400),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .ddr_user_clk(clk),
        .ddr_user_rst(rst),
        .desc_data(desc_data),
        .desc_valid(desc_valid),
        .desc_ready(desc_ready),
        .abort(abort),
        .ddr_to_mac_start(start),
        .ddr_to_mac_desc(xdesc),
        .ddr_to_mac_done(done),
        .xfer_done(xfer_done),
        .desc_cnt(desc_cnt),
        .busy(busy),
        .err_timeout(err_timeout),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] d);
        desc_data  = d;
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
    endtask

    // One-cycle done pulse; returns 5 edges after it was raised, when a
    // resulting start or xfer_done is visible.
    task automatic after_done(input string tag);
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (3) begin
            tick();
            chk({tag, "_nostart"}, 64'(start), 64'd0);
            chk({tag, "_noxdone"}, 64'(xfer_done), 64'd0);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; desc_data = '0; desc_valid = 1'b0; abort = 1'b0;
        done = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_ready", 64'(desc_ready), 64'd1);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_desc", xdesc, 64'd0);
        chk("rst_xdone", 64'(xfer_done), 64'd0);
        chk("rst_cnt", 64'(desc_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        rst = 1'b0;
        tick();

        // Single descriptor: start in the third cycle after accept.
        push({32'h40, 32'h0100_0000});
        chk("t1_idle_start", 64'(start), 64'd0);
        tick();
        chk("t1_load_start", 64'(start), 64'd0);
        tick();
        chk("t1_start", 64'(start), 64'd1);
        chk("t1_desc", xdesc, {32'h40, 32'h0100_0000});
        tick();
        chk("t1_start_pulse", 64'(start), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        done = 1'b1;
        repeat (4) begin
            tick();
            chk("t1_xdone_early", 64'(xfer_done), 64'd0);
        end
        tick();
        chk("t1_xdone", 64'(xfer_done), 64'd1);
        chk("t1_cnt", 64'(desc_cnt), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
        done = 1'b0;
        tick();
        chk("t1_xdone_pulse", 64'(xfer_done), 64'd0);
        chk("t1_desc_hold", xdesc, {32'h40, 32'h0100_0000});

        // 0xA00 bytes split into 0x400, 0x400, 0x200.
        push({32'h0A00, 32'h0100_0000});
        tick(); tick();
        chk("t2_start0", 64'(start), 64'd1);
        chk("t2_desc0", xdesc, {32'h400, 32'h0100_0000});
        tick();
        repeat (5) begin
            tick();
            chk("t2_outstanding", 64'(start), 64'd0);
        end
        after_done("t2_d0");
        chk("t2_start1", 64'(start), 64'd1);
        chk("t2_desc1", xdesc, {32'h400, 32'h0100_0400});
        chk("t2_xdone1", 64'(xfer_done), 64'd0);
        tick();
        after_done("t2_d1");
        chk("t2_start2", 64'(start), 64'd1);
        chk("t2_desc2", xdesc, {32'h200, 32'h0100_0800});
        tick();
        after_done("t2_d2");
        chk("t2_xdone", 64'(xfer_done), 64'd1);
        chk("t2_cnt", 64'(desc_cnt), 64'd2);
        chk("t2_nostart", 64'(start), 64'd0);

        // Zero-length entry is dropped; next descriptor's second chunk wraps to 0.
        push({32'h0, 32'h0000_1234});
        push({32'h800, 32'hFFFF_FC00});
        tick();
        chk("t4_zero_nostart_a", 64'(start), 64'd0);
        tick();
        chk("t4_zero_nostart_b", 64'(start), 64'd0);
        tick();
        chk("t4_start0", 64'(start), 64'd1);
        chk("t4_desc0", xdesc, {32'h400, 32'hFFFF_FC00});
        chk("t4_cnt_zero", 64'(desc_cnt), 64'd2);
        tick();
        after_done("t4_d0");
        chk("t4_start1", 64'(start), 64'd1);
        chk("t4_desc_wrap", xdesc, {32'h400, 32'h0000_0000});
        tick();
        after_done("t4_d1");
        chk("t4_xdone", 64'(xfer_done), 64'd1);
        chk("t4_cnt", 64'(desc_cnt), 64'd3);

        // Abort in WAIT with three queued descriptors.
        push({32'h40, 32'h0000_2000});
        push({32'h40, 32'h0000_2040});
        push({32'h40, 32'h0000_2080});
        push({32'h40, 32'h0000_20C0});
        chk("t5_busy_pre", 64'(busy), 64'd1);
        abort      = 1'b1;
        desc_data  = {32'h40, 32'h0000_9000};
        desc_valid = 1'b1;
        tick();
        abort      = 1'b0;
        desc_valid = 1'b0;
        chk("t5_busy_abort", 64'(busy), 64'd0);
        chk("t5_ready_abort", 64'(desc_ready), 64'd1);
        after_done("t5_late");
        chk("t5_late_xdone", 64'(xfer_done), 64'd0);
        chk("t5_cnt", 64'(desc_cnt), 64'd3);
        repeat (4) begin
            tick();
            chk("t5_quiet_start", 64'(start), 64'd0);
            chk("t5_quiet_busy", 64'(busy), 64'd0);
        end

        // Fill: one in flight plus eight queued deasserts desc_ready.
        for (int i = 0; i < 9; i++) begin
            push({32'h40, 32'h0000_3000 + 32'(i) * 32'h40});
            chk("t3_ready_fill", 64'(desc_ready), (i < 8) ? 64'd1 : 64'd0);
        end
        desc_data  = {32'h40, 32'h0000_3240};
        desc_valid = 1'b1;
        repeat (3) begin
            tick();
            chk("t3_held_off", 64'(desc_ready), 64'd0);
        end
        after_done("t3_d");
        chk("t3_xdone", 64'(xfer_done), 64'd1);
        chk("t3_cnt", 64'(desc_cnt), 64'd4);
        chk("t3_ready_still_full", 64'(desc_ready), 64'd0);
        tick();
        chk("t3_ready_after_pop", 64'(desc_ready), 64'd1);
        tick();
        desc_valid = 1'b0;
        chk("t3_ready_refull", 64'(desc_ready), 64'd0);
        chk("t3_start_next", 64'(start), 64'd1);
        chk("t3_desc_next", xdesc, {32'h40, 32'h0000_3040});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_flush_busy", 64'(busy), 64'd0);
        tick(); tick(); tick();

`ifdef SCHED_TIMEOUT_EN
        // Done withheld: watchdog fires after 100 WAIT cycles, queue continues.
        push({32'h40, 32'h0000_5000});
        push({32'h40, 32'h0000_6000});
        tick();
        chk("t6_start0", 64'(start), 64'd1);
        chk("t6_desc0", xdesc, {32'h40, 32'h0000_5000});
        repeat (100) tick();
        chk("t6_err_early", 64'(err_timeout), 64'd0);
        tick();
        chk("t6_err_set", 64'(err_timeout), 64'd1);
        chk("t6_cnt", 64'(desc_cnt), 64'd4);
        chk("t6_xdone", 64'(xfer_done), 64'd0);
        tick(); tick();
        chk("t6_start1", 64'(start), 64'd1);
        chk("t6_desc1", xdesc, {32'h40, 32'h0000_6000});
        chk("t6_err_sticky", 64'(err_timeout), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t6_err_clr", 64'(err_timeout), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`else
        push({32'h40, 32'h0000_5000});
        repeat (150) tick();
        chk("t6_no_timeout", 64'(err_timeout), 64'd0);
        chk("t6_still_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
        tick();
        chk("end_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
